// File: rtl/gf180_sram_narrow_adapter.sv
// 32-bit req/gnt front end for a 64-bit latency-1 gf180mcu SRAM cut.
// Optionally zero-fills the macro after reset before granting traffic.
module gf180_sram_narrow_adapter #(
    parameter int unsigned NumWords     = 1024,
    parameter bit          ClearOnReset = 1'b1,
    parameter int unsigned AddrWidth    = $clog2(NumWords)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_i,
    output logic                   gnt_o,
    input  logic                   we_i,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic [31:0]            wdata_i,
    input  logic [3:0]             be_i,
    output logic                   rvalid_o,
    output logic [31:0]            rdata_o,
    output logic                   err_o,
    output logic                   init_done_o,
    output logic                   sram_req_o,
    output logic                   sram_we_o,
    output logic [AddrWidth-2:0]   sram_addr_o,
    output logic [63:0]            sram_wdata_o,
    output logic [7:0]             sram_be_o,
    input  logic [63:0]            sram_rdata_i
);

    localparam int unsigned MacroWidth = AddrWidth - 1;
    localparam logic [MacroWidth-1:0] LastWord = MacroWidth'(NumWords / 2 - 1);
    localparam logic [AddrWidth:0] Limit = (AddrWidth + 1)'(NumWords);

    if ((NumWords % 2) != 0 || NumWords < 4) begin : g_bad_depth
        $fatal(1, "NumWords must be even and at least 4");
    end

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    state_t                 state;
    logic [MacroWidth-1:0]  cnt;
    logic                   init_done;
    logic                   rvalid_q;
    logic                   rsp_we;
    logic                   rsp_half;
    logic                   rsp_err;

    logic                   accept;
    logic                   out_of_range;
    logic                   access;
    logic                   clearing;

    // Outputs are masked while rst_i is high so the reset values hold in that cycle.
    always_comb begin
        accept       = (state == ST_IDLE) && req_i && !rst_i;
        out_of_range = ({1'b0, addr_i} >= Limit);
        access       = accept && !out_of_range;
        clearing     = (state == ST_CLEAR) && !rst_i;
    end

    always_comb begin
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        if (clearing) begin
            sram_req_o  = 1'b1;
            sram_we_o   = 1'b1;
            sram_addr_o = cnt;
            sram_be_o   = '1;
        end else if (access) begin
            sram_req_o   = 1'b1;
            sram_we_o    = we_i;
            sram_addr_o  = addr_i[AddrWidth-1:1];
            sram_wdata_o = {wdata_i, wdata_i};
            if (we_i) begin
                sram_be_o = addr_i[0] ? {be_i, 4'h0} : {4'h0, be_i};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ClearOnReset ? ST_CLEAR : ST_IDLE;
            cnt       <= '0;
            init_done <= !ClearOnReset;
            rvalid_q  <= 1'b0;
            rsp_we    <= 1'b0;
            rsp_half  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LastWord) begin
                        state     <= ST_IDLE;
                        init_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            rvalid_q <= accept;
            rsp_we   <= we_i;
            rsp_half <= addr_i[0];
            rsp_err  <= out_of_range;
        end
    end

    always_comb begin
        gnt_o       = accept;
        init_done_o = init_done;
        rvalid_o    = rvalid_q && !rst_i;
        err_o       = rvalid_o && rsp_err;
        rdata_o     = '0;
        if (rvalid_o && !rsp_we && !rsp_err) begin
            rdata_o = rsp_half ? sram_rdata_i[63:32] : sram_rdata_i[31:0];
        end
    end

endmodule

// File: tb/tb_gf180_sram_narrow_adapter.sv
// Scoreboard bench: a 1024-word clearing instance plus a 1000-word
// non-clearing instance for the out-of-range path.
module tb_gf180_sram_narrow_adapter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req, we, gnt, rvalid, err, init_done;
    logic [9:0]  addr;
    logic [31:0] wdata, rdata;
    logic [3:0]  be;
    logic        sram_req, sram_we;
    logic [8:0]  sram_addr;
    logic [63:0] sram_wdata, sram_rdata;
    logic [7:0]  sram_be;

    logic        req_b, we_b, gnt_b, rvalid_b, err_b, init_done_b;
    logic [9:0]  addr_b;
    logic [31:0] rdata_b;
    logic        sram_req_b, sram_we_b;
    logic [8:0]  sram_addr_b;
    logic [63:0] sram_wdata_b, sram_rdata_b;
    logic [7:0]  sram_be_b;

    logic        model_fill;
    logic [63:0] mem [512];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t q[$];
    rsp_t qb[$];

    gf180_sram_narrow_adapter #(
        .NumWords(1024),
        .ClearOnReset(1'b1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .we_i(we),
        .addr_i(addr), .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid),
        .rdata_o(rdata), .err_o(err), .init_done_o(init_done),
        .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
        .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
    );

    gf180_sram_narrow_adapter #(
        .NumWords(1000),
        .ClearOnReset(1'b0)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .req_i(req_b), .gnt_o(gnt_b), .we_i(we_b),
        .addr_i(addr_b), .wdata_i(32'h0), .be_i(4'h0), .rvalid_o(rvalid_b),
        .rdata_o(rdata_b), .err_o(err_b), .init_done_o(init_done_b),
        .sram_req_o(sram_req_b), .sram_we_o(sram_we_b), .sram_addr_o(sram_addr_b),
        .sram_wdata_o(sram_wdata_b), .sram_be_o(sram_be_b), .sram_rdata_i(sram_rdata_b)
    );

    // Macro model: latency-1, byte-masked writes; starts all-ones so the clear sweep is observable.
    always @(posedge clk) begin
        if (model_fill) begin
            for (int i = 0; i < 512; i++) mem[i] <= '1;
        end else if (sram_req) begin
            for (int b = 0; b < 8; b++) begin
                if (sram_we && sram_be[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
            end
            sram_rdata <= mem[sram_addr];
        end
    end

    always @(posedge clk) begin
        if (sram_req_b)
            sram_rdata_b <= {32'hB0B0_0000 | 32'(sram_addr_b), 32'hA0A0_0000 | 32'(sram_addr_b)};
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        rsp_t e;
        if (rvalid) begin
            if (q.size() == 0) begin
                check("unexpected_rvalid", {rdata, err}, 128'h0);
                check("unexpected_rvalid_flag", 128'(rvalid), 128'h0);
            end else begin
                e = q.pop_front();
                check("rsp", {rdata, err}, {e.rdata, e.err});
            end
        end
    end

    always @(negedge clk) begin
        rsp_t e;
        if (rvalid_b) begin
            if (qb.size() == 0) begin
                check("unexpected_rvalid_b", 128'(rvalid_b), 128'h0);
            end else begin
                e = qb.pop_front();
                check("rsp_b", {rdata_b, err_b}, {e.rdata, e.err});
            end
        end
    end

    task automatic sweep(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            check("sweep", {init_done, gnt, sram_req, sram_we, sram_be, sram_wdata, sram_addr},
                  {1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 64'h0, 9'(i)});
            @(posedge clk); #1;
        end
    endtask

    task automatic drive(input logic w, input logic [9:0] a, input logic [31:0] d,
                         input logic [3:0] b, input logic [8:0] ea, input logic [7:0] ebe,
                         input logic [31:0] er, input bit expect_rsp);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        @(negedge clk);
        check("gnt", 128'(gnt), 128'h1);
        check("sram", {sram_req, sram_we, sram_addr, sram_be, sram_wdata},
              {1'b1, w, ea, ebe, d, d});
        if (expect_rsp) q.push_back('{er, 1'b0});
        @(posedge clk); #1;
    endtask

    task automatic idle(input int unsigned n);
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_no_access", {gnt, sram_req}, 128'h0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1; model_fill = 1'b1;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        req_b = 1'b0; we_b = 1'b0; addr_b = '0;
        @(posedge clk); #1;
        model_fill = 1'b0;
        @(negedge clk);
        check("reset", {gnt, rvalid, err, rdata, init_done, sram_req, sram_we, sram_be, sram_addr, sram_wdata},
              128'h0);
        check("reset_b_init_done", {init_done_b, sram_req_b, rvalid_b}, {1'b1, 1'b0, 1'b0});
        @(posedge clk); #1;

        // T1: sweep with a request pending the whole time
        rst = 1'b0; req = 1'b1;
        sweep(512);
        req = 1'b0;
        @(negedge clk);
        check("init_done", {init_done, sram_req}, {1'b1, 1'b0});
        @(posedge clk); #1;

        // T2
        drive(1'b1, 10'd5, 32'hDEADBEEF, 4'hF, 9'd2, 8'hF0, 32'h0, 1'b1);
        idle(2);
        // T3
        drive(1'b1, 10'd4, 32'h12345678, 4'b0011, 9'd2, 8'h03, 32'h0, 1'b1);
        idle(1);
        drive(1'b0, 10'd4, 32'h0, 4'h0, 9'd2, 8'h00, 32'h00005678, 1'b1);
        drive(1'b0, 10'd5, 32'h0, 4'h0, 9'd2, 8'h00, 32'hDEADBEEF, 1'b1);
        idle(2);
        // T4: back-to-back with read-after-write on the same word
        drive(1'b1, 10'd6, 32'h1, 4'hF, 9'd3, 8'h0F, 32'h0, 1'b1);
        drive(1'b0, 10'd6, 32'h0, 4'h0, 9'd3, 8'h00, 32'h1, 1'b1);
        drive(1'b1, 10'd7, 32'h2, 4'hF, 9'd3, 8'hF0, 32'h0, 1'b1);
        drive(1'b0, 10'd7, 32'h0, 4'h0, 9'd3, 8'h00, 32'h2, 1'b1);
        idle(2);

        // T5: out-of-range on the 1000-word instance, then its last valid word
        req_b = 1'b1; we_b = 1'b0; addr_b = 10'd1000;
        @(negedge clk);
        check("oor_gnt", 128'(gnt_b), 128'h1);
        check("oor_no_sram", {sram_req_b, sram_we_b, sram_be_b}, 128'h0);
        qb.push_back('{32'h0, 1'b1});
        @(posedge clk); #1;
        addr_b = 10'd999;
        @(negedge clk);
        check("b_last_word", {sram_req_b, sram_we_b, sram_addr_b, sram_be_b}, {1'b1, 1'b0, 9'd499, 8'h00});
        qb.push_back('{32'hB0B0_01F3, 1'b0});
        @(posedge clk); #1;
        req_b = 1'b0;
        idle(2);

        // T6a: reset at sweep cycle 100 restarts the sweep at word 0
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sweep(100);
        rst = 1'b1;
        @(negedge clk);
        check("mid_sweep_reset", {sram_req, gnt}, 128'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        sweep(512);
        idle(1);
        check("init_done_after_restart", 128'(init_done), 128'h1);

        // T6b: reset in the cycle after an accepted read drops its response
        drive(1'b0, 10'd4, 32'h0, 4'h0, 9'd2, 8'h00, 32'h0, 1'b0);
        req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rvalid_dropped", {rvalid, err, rdata}, 128'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("queue_empty", 128'(q.size() + qb.size()), 128'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
